// File: rtl/enc_pkg.sv
// Shared quadrature state constants and the step classifier used by the
// encoder decoder.
package enc_pkg;

  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_10 = 2'b10;
  localparam logic [1:0] ST_11 = 2'b11;
  localparam logic [1:0] ST_01 = 2'b01;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ILL
  } step_e;

  // Forward (A leads B) successor in the Gray cycle 00->10->11->01->00.
  function automatic logic [1:0] fwd_next(input logic [1:0] st);
    case (st)
      ST_00:   fwd_next = ST_10;
      ST_10:   fwd_next = ST_11;
      ST_11:   fwd_next = ST_01;
      default: fwd_next = ST_00;
    endcase
  endfunction

  function automatic step_e classify_step(input logic [1:0] old_st,
                                          input logic [1:0] new_st);
    if ((old_st ^ new_st) == 2'b11)         classify_step = STEP_ILL;
    else if (new_st == fwd_next(old_st))    classify_step = STEP_FWD;
    else if (old_st == fwd_next(new_st))    classify_step = STEP_REV;
    else                                    classify_step = STEP_NONE;
  endfunction

endpackage

// File: rtl/enc_input_filter.sv
// Synchronizes the raw A/B pair and accepts a new value only after it has
// differed from the accepted state for FILTER_CYCLES consecutive samples.
module enc_input_filter
  import enc_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ab_i,
  output logic [1:0] f_o,
  output logic       commit_o,
  output logic [1:0] old_o,
  output logic [1:0] new_o
);

  localparam int KW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(FILTER_CYCLES - 1);

  logic [1:0]    sync_q [SYNC_STAGES];
  logic [1:0]    samp_q;
  logic [1:0]    f_q, f_d;
  logic [KW-1:0] k_q, k_d;
  logic          commit;

  always_comb begin
    f_d    = f_q;
    k_d    = k_q;
    commit = 1'b0;
    if (samp_q == f_q) begin
      k_d = '0;
    end else if (k_q == K_LAST) begin
      commit = 1'b1;
      f_d    = samp_q;
      k_d    = '0;
    end else begin
      k_d = k_q + 1'b1;
    end
  end

  // samp_q is the filter's sampling register: a change settled before edge 0
  // commits on edge SYNC_STAGES+FILTER_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b00;
      samp_q <= 2'b00;
      f_q    <= ST_00;
      k_q    <= '0;
    end else begin
      sync_q[0] <= ab_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      samp_q <= sync_q[SYNC_STAGES-1];
      f_q    <= f_d;
      k_q    <= k_d;
    end
  end

  assign f_o      = f_q;
  assign commit_o = commit;
  assign old_o    = f_q;
  assign new_o    = samp_q;

endmodule

// File: rtl/incremental_encoder_controller.sv
// Quadrature encoder decoder: filtered A/B state, direction, step strobe,
// illegal-transition strobe and a wrapping up/down position counter.
module incremental_encoder_controller
  import enc_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 A,
  input  logic                 B,
  output logic                 dir,
  output logic                 clkEnable,
  output logic [1:0]           curState,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 err
);

  logic [1:0]           f_st, old_st, new_st;
  logic                 commit;
  step_e                step;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 dir_q, dir_d;
  logic                 ce_q, ce_d;
  logic                 err_q, err_d;

  enc_input_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filter (
    .clk     (clk),
    .rst     (rst),
    .ab_i    ({A, B}),
    .f_o     (f_st),
    .commit_o(commit),
    .old_o   (old_st),
    .new_o   (new_st)
  );

  always_comb begin
    step  = commit ? classify_step(old_st, new_st) : STEP_NONE;
    cnt_d = cnt_q;
    dir_d = dir_q;
    ce_d  = 1'b0;
    err_d = 1'b0;
    case (step)
      STEP_FWD: begin
        cnt_d = cnt_q + 1'b1;
        dir_d = DIR_FWD;
        ce_d  = 1'b1;
      end
      STEP_REV: begin
        cnt_d = cnt_q - 1'b1;
        dir_d = DIR_REV;
        ce_d  = 1'b1;
      end
      STEP_ILL: err_d = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      dir_q <= DIR_REV;
      ce_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      ce_q  <= ce_d;
      err_q <= err_d;
    end
  end

  assign curState  = f_st;
  assign cnt       = cnt_q;
  assign dir       = dir_q;
  assign clkEnable = ce_q;
  assign err       = err_q;

endmodule

// File: tb/tb_incremental_encoder_controller.sv
// Bench for incremental_encoder_controller: directed scenarios with literal
// expectations plus randomized A/B traffic against a behavioural model.
module tb_incremental_encoder_controller;

  localparam int SYNC = 2;
  localparam int FC   = 4;
  localparam int CW   = 32;
  localparam int LAT  = SYNC + FC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          A   = 1'b0;
  logic          B   = 1'b0;
  logic          dir, clkEnable, err;
  logic [1:0]    curState;
  logic [CW-1:0] cnt;

  incremental_encoder_controller #(
    .SYNC_STAGES  (SYNC),
    .FILTER_CYCLES(FC),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .dir      (dir),
    .clkEnable(clkEnable),
    .curState (curState),
    .cnt      (cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rst_edge = 0;
  logic [1:0] hist [int];

  logic [1:0]    mf;
  int            run;
  logic [CW-1:0] mcnt;
  logic          mdir, mce, merr;

  int ce_count = 0;
  int err_count = 0;
  int ce_edges[$];
  int err_edges[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Position of a state around the forward Gray cycle 00,10,11,01.
  function automatic int pos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Reference model: the filter sees the input applied SYNC+1 edges earlier
  // (zero inside the reset shadow) and commits after FC mismatching samples.
  always @(posedge clk) begin : model
    logic [1:0] s;
    cyc++;
    hist[cyc] = {A, B};
    mce  = 1'b0;
    merr = 1'b0;
    if (rst) begin
      rst_edge = cyc;
      mf   = 2'b00;
      run  = 0;
      mcnt = '0;
      mdir = 1'b0;
    end else begin
      s = (cyc - (SYNC + 1) > rst_edge) ? hist[cyc - (SYNC + 1)] : 2'b00;
      if (s == mf) begin
        run = 0;
      end else if (run + 1 == FC) begin
        if ((mf ^ s) == 2'b11) merr = 1'b1;
        else if ((pos(s) - pos(mf) + 4) % 4 == 1) begin
          mcnt = mcnt + 1; mdir = 1'b1; mce = 1'b1;
        end else begin
          mcnt = mcnt - 1; mdir = 1'b0; mce = 1'b1;
        end
        mf  = s;
        run = 0;
      end else begin
        run++;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("model_curState", 32'(curState), 32'(mf));
      chk("model_cnt", cnt, mcnt);
      chk("model_dir", 32'(dir), 32'(mdir));
      chk("model_clkEnable", 32'(clkEnable), 32'(mce));
      chk("model_err", 32'(err), 32'(merr));
      if (clkEnable === 1'b1) begin ce_count++; ce_edges.push_back(cyc); end
      if (err === 1'b1) begin err_count++; err_edges.push_back(cyc); end
    end
  end

  task automatic do_reset(input logic [1:0] ab, input int n);
    @(negedge clk);
    rst = 1'b1;
    {A, B} = ab;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic hold(input logic [1:0] ab, input int n);
    {A, B} = ab;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c0, e0, rel0, idx0, hlen;
    int chg[4];
    logic [1:0] seq[4];
    seq = '{2'b10, 2'b11, 2'b01, 2'b00};

    // Reset with inputs at 11, then the illegal 00->11 commit.
    do_reset(2'b11, 3);
    chk("rst_cnt", cnt, 32'd0);
    chk("rst_curState", 32'(curState), 32'd0);
    chk("rst_dir", 32'(dir), 32'd0);
    chk("rst_clkEnable", 32'(clkEnable), 32'd0);
    e0 = err_count; c0 = ce_count; rel0 = cyc + 1;
    repeat (10) @(negedge clk);
    chk("post_rst_err_pulses", 32'(err_count - e0), 32'd1);
    if (err_edges.size() > 0)
      chk("post_rst_err_edge", 32'(err_edges[err_edges.size()-1] - rel0), 32'd6);
    chk("post_rst_curState", 32'(curState), 32'd3);
    chk("post_rst_cnt", cnt, 32'd0);
    chk("post_rst_no_step", 32'(ce_count - c0), 32'd0);

    // Forward sequence, each state held 10 cycles.
    do_reset(2'b00, 2);
    c0 = ce_count; idx0 = ce_edges.size();
    for (int i = 0; i < 4; i++) begin
      chg[i] = cyc + 1;
      hold(seq[i], 10);
      chk("fwd_cnt", cnt, 32'(i + 1));
      chk("fwd_curState", 32'(curState), 32'(seq[i]));
      chk("fwd_dir", 32'(dir), 32'd1);
    end
    chk("fwd_pulses", 32'(ce_count - c0), 32'd4);
    if (ce_edges.size() >= idx0 + 4)
      for (int i = 0; i < 4; i++)
        chk("fwd_latency", 32'(ce_edges[idx0 + i] - chg[i]), 32'(LAT));

    // Reverse step from zero wraps, then forward step wraps back.
    do_reset(2'b00, 2);
    c0 = ce_count;
    hold(2'b01, 10);
    chk("wrap_down_cnt", cnt, 32'hFFFF_FFFF);
    chk("wrap_down_dir", 32'(dir), 32'd0);
    chk("wrap_down_pulses", 32'(ce_count - c0), 32'd1);
    hold(2'b00, 10);
    chk("wrap_up_cnt", cnt, 32'd0);
    chk("wrap_up_dir", 32'(dir), 32'd1);

    // Glitch of 3 cycles is rejected.
    do_reset(2'b00, 2);
    c0 = ce_count; e0 = err_count;
    hold(2'b10, 3);
    hold(2'b00, 12);
    chk("glitch3_curState", 32'(curState), 32'd0);
    chk("glitch3_cnt", cnt, 32'd0);
    chk("glitch3_pulses", 32'(ce_count - c0 + err_count - e0), 32'd0);

    // Pulse of 4 cycles is accepted, then the return is a reverse step.
    c0 = ce_count;
    hold(2'b10, 4);
    hold(2'b00, 3);
    chk("pulse4_cnt", cnt, 32'd1);
    chk("pulse4_curState", 32'(curState), 32'd2);
    chk("pulse4_dir", 32'(dir), 32'd1);
    hold(2'b00, 10);
    chk("pulse4_back_cnt", cnt, 32'd0);
    chk("pulse4_back_curState", 32'(curState), 32'd0);
    chk("pulse4_back_dir", 32'(dir), 32'd0);
    chk("pulse4_pulses", 32'(ce_count - c0), 32'd2);

    // Mid-sequence reset after three forward steps.
    do_reset(2'b00, 2);
    for (int i = 0; i < 3; i++) hold(seq[i], 10);
    chk("mid_cnt_before", cnt, 32'd3);
    rst = 1'b1;
    {A, B} = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_cnt", cnt, 32'd0);
    chk("mid_rst_curState", 32'(curState), 32'd0);
    chk("mid_rst_dir", 32'(dir), 32'd0);
    hold(2'b10, 10);
    chk("mid_resume_cnt", cnt, 32'd1);
    chk("mid_resume_dir", 32'(dir), 32'd1);
    chk("mid_resume_curState", 32'(curState), 32'd2);

    // Randomized traffic: short glitches, legal and illegal moves, resets.
    do_reset(2'b00, 2);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        rst = 1'b1;
        {A, B} = 2'($urandom_range(0, 3));
        @(negedge clk);
        rst = 1'b0;
      end else begin
        hlen = $urandom_range(1, 12);
        hold(2'($urandom_range(0, 3)), hlen);
      end
    end
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
